// File: rtl/ps2_key_sequencer.sv
// Key-event FIFO plus byte sequencer that expands each event into PS/2 set-2
// make/break bytes and paces them into ps2_tx with gap, hold and resend timing.
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int GAP_CYCLES  = 2000,
    parameter int HOLD_CYCLES = 50000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    key_code,
    input  logic                          key_ext,
    input  logic                          key_shift,
    input  logic                          key_valid,
    output logic                          key_ready,
    output logic [7:0]                    scancode,
    output logic                          send,
    input  logic                          ready,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int CNT_MAX0 = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > ACK_TIMEOUT) ? CNT_MAX0 : ACK_TIMEOUT;
    localparam int CW       = $clog2(CNT_MAX + 2);

    // Last count value of each timed state; a zero setting still costs one cycle.
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ACK_LAST  = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_POP       = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;
    localparam logic [2:0] ST_HOLD      = 3'd6;

    localparam logic [3:0] STP_HOLD = 4'd3;
    localparam logic [3:0] STP_NONE = 4'd9;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [2:0]    r_state;
    logic [3:0]    r_step;
    logic [CW-1:0] r_cnt;
    logic          r_send;
    logic [7:0]    r_scancode;
    logic          r_overflow;
    logic [7:0]    r_code;
    logic          r_ext;
    logic          r_shift;

    logic [9:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf;
    logic [3:0]    w_first;
    logic [3:0]    w_next;

    // Steps 0..8: S0 shift, S1 E0, S2 code, HOLD, S3 E0, S4 F0, S5 code, S6 F0, S7 shift.
    function automatic logic step_en(input logic [3:0] s, input logic ext, input logic shift);
        case (s)
            4'd0, 4'd7, 4'd8:       step_en = shift;
            4'd1, 4'd4:             step_en = ext;
            4'd2, 4'd3, 4'd5, 4'd6: step_en = 1'b1;
            default:                step_en = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] first_from(input logic [3:0] start, input logic ext,
                                              input logic shift);
        logic [3:0] r;
        r = STP_NONE;
        for (int i = 8; i >= 0; i--) begin
            if (i >= int'(start) && step_en(4'(i), ext, shift)) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] step_byte(input logic [3:0] s, input logic [7:0] code);
        case (s)
            4'd0, 4'd8: step_byte = 8'h12;
            4'd1, 4'd4: step_byte = 8'hE0;
            4'd5, 4'd7: step_byte = 8'hF0;
            default:    step_byte = code;
        endcase
    endfunction

    assign w_head  = r_mem[r_rptr];
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = (r_state == ST_POP);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign w_push  = key_valid && (!w_full || w_pop);
    assign w_ovf   = key_valid && w_full && !w_pop;
    assign w_first = first_from(4'd0, w_head[8], w_head[9]);
    assign w_next  = first_from(r_step + 4'd1, r_ext, r_shift);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_cnt      <= '0;
            r_send     <= 1'b0;
            r_scancode <= 8'h00;
            r_overflow <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
        end else begin
            r_send     <= 1'b0;
            r_overflow <= w_ovf;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);

            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_POP;
                        r_cnt   <= '0;
                    end
                end
                ST_POP: begin
                    r_step  <= w_first;
                    r_state <= ST_ISSUE;
                    r_cnt   <= '0;
                end
                ST_ISSUE: begin
                    if (ready) begin
                        r_send     <= 1'b1;
                        r_scancode <= step_byte(r_step, r_code);
                        r_state    <= ST_WAIT_ACK;
                        r_cnt      <= '0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!ready) begin
                        r_state <= ST_WAIT_DONE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= ACK_LAST) begin
                        r_state <= ST_ISSUE;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ready) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    if (r_cnt >= GAP_LAST) begin
                        r_step <= w_next;
                        r_cnt  <= '0;
                        if (w_next == STP_HOLD)      r_state <= ST_HOLD;
                        else if (w_next != STP_NONE) r_state <= ST_ISSUE;
                        else if (!w_empty)           r_state <= ST_POP;
                        else                         r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt >= HOLD_LAST) begin
                        r_step  <= w_next;
                        r_state <= ST_ISSUE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {key_shift, key_ext, key_code};
        if (w_pop) {r_shift, r_ext, r_code} <= w_head;
    end

    assign key_ready  = !w_full;
    assign scancode   = r_scancode;
    assign send       = r_send;
    assign busy       = (r_state != ST_IDLE) || !w_empty;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
